// File: rtl/booth_div_seq_if.sv
// Handshake and operand/result bundle for the sequential signed divider.
interface booth_div_seq_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;
  logic             overflow;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero, overflow
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero, overflow
  );
endinterface

// File: rtl/booth_div_seq.sv
// Sequential signed divider: restoring shift-subtract on operand magnitudes,
// followed by sign correction and divide-by-zero / overflow handling.
module booth_div_seq #(
  parameter int WIDTH = 4
) (
  input logic           clk,
  input logic           rst,
  booth_div_seq_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  state_t state, state_next;

  logic             sign_q, sign_r;
  logic [WIDTH-1:0] dvd_raw, dvs_abs;
  logic [WIDTH-1:0] p, q;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] quo_r, rem_r;
  logic             dbz_r, ovf_r;

  logic [WIDTH-1:0] dvd_abs_in, dvs_abs_in;
  logic [WIDTH:0]   p_sh;
  logic             ge;
  logic [WIDTH-1:0] p_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // CALC holds one extra cycle at cnt==0 so done lands WIDTH+2 edges after start.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (bus.start) state_next = CALC;
      CALC:    if (cnt == '0) state_next = FIX;
      FIX:     state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    dvd_abs_in = bus.dividend[WIDTH-1] ? -bus.dividend : bus.dividend;
    dvs_abs_in = bus.divisor[WIDTH-1]  ? -bus.divisor  : bus.divisor;
    p_sh       = {p, q[WIDTH-1]};
    ge         = (p_sh >= {1'b0, dvs_abs});
    p_next     = ge ? WIDTH'(p_sh - {1'b0, dvs_abs}) : p_sh[WIDTH-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sign_q  <= 1'b0;
      sign_r  <= 1'b0;
      dvd_raw <= '0;
      dvs_abs <= '0;
      p       <= '0;
      q       <= '0;
      cnt     <= '0;
      quo_r   <= '0;
      rem_r   <= '0;
      dbz_r   <= 1'b0;
      ovf_r   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (bus.start) begin
          sign_q  <= bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
          sign_r  <= bus.dividend[WIDTH-1];
          dvd_raw <= bus.dividend;
          dvs_abs <= dvs_abs_in;
          p       <= '0;
          q       <= dvd_abs_in;
          cnt     <= CW'(WIDTH);
        end
        CALC: if (cnt != '0) begin
          p   <= p_next;
          q   <= {q[WIDTH-2:0], ge};
          cnt <= cnt - CW'(1);
        end
        FIX: begin
          if (dvs_abs == '0) begin
            quo_r <= '1;
            rem_r <= dvd_raw;
            dbz_r <= 1'b1;
            ovf_r <= 1'b0;
          end else begin
            quo_r <= sign_q ? -q : q;
            rem_r <= sign_r ? -p : p;
            dbz_r <= 1'b0;
            // Divisor sign is sign_q ^ sign_r; the wrapped quotient is already correct.
            ovf_r <= (dvd_raw == MOST_NEG) && (dvs_abs == ONE) && (sign_q ^ sign_r);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy        = (state == CALC) || (state == FIX);
  assign bus.done        = (state == DONE);
  assign bus.quotient    = quo_r;
  assign bus.remainder   = rem_r;
  assign bus.div_by_zero = dbz_r;
  assign bus.overflow    = ovf_r;
endmodule

// File: tb/tb_booth_div_seq.sv
// Directed and exhaustive self-checking bench for booth_div_seq at WIDTH=4.
module tb_booth_div_seq;
  localparam int W = 4;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  booth_div_seq_if #(.WIDTH(W)) bus ();

  booth_div_seq #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One division; optional second start pulse mid-operation that must be ignored.
  task automatic run_div(input string tag, input int a, input int b, input bit inject,
                         input logic [W-1:0] eq, input logic [W-1:0] er,
                         input logic edbz, input logic eovf);
    int k;
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = a[W-1:0];
    bus.divisor  = b[W-1:0];
    @(posedge clk); #1;
    bus.start = 1'b0;
    k = 0;
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk); #1;
      if (i == 1) chk({tag, " busy"}, {31'b0, bus.busy}, 32'd1);
      if (inject && i == 2) begin
        bus.start    = 1'b1;
        bus.dividend = 4'd7;
        bus.divisor  = 4'd2;
      end
      if (inject && i == 3) bus.start = 1'b0;
      if (bus.done) begin
        k = i;
        break;
      end
    end
    chk({tag, " latency"}, k, 32'd6);
    chk({tag, " quotient"}, {28'b0, bus.quotient}, {28'b0, eq});
    chk({tag, " remainder"}, {28'b0, bus.remainder}, {28'b0, er});
    chk({tag, " div_by_zero"}, {31'b0, bus.div_by_zero}, {31'b0, edbz});
    chk({tag, " overflow"}, {31'b0, bus.overflow}, {31'b0, eovf});
    chk({tag, " busy_at_done"}, {31'b0, bus.busy}, 32'd0);
    @(posedge clk); #1;
    chk({tag, " done_single"}, {31'b0, bus.done}, 32'd0);
  endtask

  initial begin
    int mq, mr, qi, ri, ra, rb;
    logic edbz, eovf;
    bit seen_done;
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    #1;
    chk("rst busy", {31'b0, bus.busy}, 32'd0);
    chk("rst done", {31'b0, bus.done}, 32'd0);
    chk("rst quotient", {28'b0, bus.quotient}, 32'd0);
    chk("rst remainder", {28'b0, bus.remainder}, 32'd0);
    chk("rst flags", {30'b0, bus.div_by_zero, bus.overflow}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    run_div("7/2",   7,  2, 1'b0, 4'b0011, 4'b0001, 1'b0, 1'b0);
    run_div("-7/2", -7,  2, 1'b0, 4'b1101, 4'b1111, 1'b0, 1'b0);
    run_div("7/-2",  7, -2, 1'b0, 4'b1101, 4'b0001, 1'b0, 1'b0);
    run_div("-8/-1", -8, -1, 1'b0, 4'b1000, 4'b0000, 1'b0, 1'b1);
    run_div("-8/1", -8,  1, 1'b0, 4'b1000, 4'b0000, 1'b0, 1'b0);
    run_div("5/0",   5,  0, 1'b0, 4'b1111, 4'b0101, 1'b1, 1'b0);
    run_div("6/3+ign", 6, 3, 1'b1, 4'b0010, 4'b0000, 1'b0, 1'b0);

    // Reset mid-CALC: outputs clear asynchronously and no done follows.
    @(negedge clk);
    bus.start = 1'b1; bus.dividend = 4'd6; bus.divisor = 4'd3;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("midrst busy", {31'b0, bus.busy}, 32'd0);
    chk("midrst done", {31'b0, bus.done}, 32'd0);
    chk("midrst quotient", {28'b0, bus.quotient}, 32'd0);
    chk("midrst remainder", {28'b0, bus.remainder}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    seen_done = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (bus.done) seen_done = 1'b1;
    end
    chk("midrst no_done", {31'b0, seen_done}, 32'd0);

    // Exhaustive sweep against an integer reference model.
    for (int a = -8; a <= 7; a++) begin
      for (int b = -8; b <= 7; b++) begin
        edbz = 1'b0;
        eovf = 1'b0;
        if (b == 0) begin
          mq = -1; mr = a; edbz = 1'b1;
        end else if (a == -8 && b == -1) begin
          mq = -8; mr = 0; eovf = 1'b1;
        end else begin
          mq = a / b; mr = a % b;
        end
        run_div($sformatf("%0d/%0d", a, b), a, b, 1'b0, mq[W-1:0], mr[W-1:0], edbz, eovf);
        if (b != 0 && !(a == -8 && b == -1)) begin
          qi = $signed(bus.quotient);
          ri = $signed(bus.remainder);
          ra = (ri < 0) ? -ri : ri;
          rb = (b < 0) ? -b : b;
          chk($sformatf("%0d/%0d invariant", a, b), qi * b + ri, a);
          chk($sformatf("%0d/%0d rem_bound", a, b), {31'b0, ra < rb}, 32'd1);
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/booth_div_seq.md
Name: booth_div_seq

Overview:
- Sequential signed integer divider; the inverse operation to the team's Booth multiplier.
- Computes quotient and remainder of two's-complement operands with a start/done handshake.
- Uses a restoring shift-subtract loop on operand magnitudes, then sign correction.
- Sits beside the multiplier in the arithmetic datapath. It is shared by control logic that issues one division at a time.

Parameters:
- WIDTH, 4, bit width of dividend, divisor, quotient and remainder (WIDTH >= 2).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request pulse; sampled only in IDLE.
- dividend  input  WIDTH  signed dividend; captured on the accepted start edge.
- divisor  input  WIDTH  signed divisor; captured on the accepted start edge.
- busy  output  1  high from the cycle after an accepted start until done is asserted.
- done  output  1  one-cycle pulse when results are valid.
- quotient  output  WIDTH  signed quotient, truncated toward zero.
- remainder  output  WIDTH  signed remainder; takes the sign of the dividend.
- div_by_zero  output  1  set with done when divisor == 0.
- overflow  output  1  set with done for most-negative / -1.

Behaviour:
- Reset (asynchronous): state=IDLE. busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, overflow=0. Internal registers and iteration counter cleared.
- Reset mid-operation aborts the division immediately. No done is produced.
- States:
  - IDLE: start=1 captures the operands and moves to CALC.
  - CALC: runs exactly WIDTH iterations, then moves to FIX.
  - FIX: one cycle, then moves to DONE.
  - DONE: one cycle, then returns to IDLE.
- Capture on start:
  - Store sign_q = sign(dividend) XOR sign(divisor) and sign_r = sign(dividend).
  - Store |dividend| and |divisor| as WIDTH-bit unsigned values. |most-negative| = 2^(WIDTH-1) fits unsigned.
  - Clear the WIDTH+1-bit partial remainder P. Load Q = |dividend|. Counter = WIDTH.
- CALC iteration, per cycle:
  - {P,Q} shifted left by 1.
  - If P >= |divisor|: P = P - |divisor|, Q[0] = 1. Otherwise Q[0] = 0.
  - Decrement counter. Leave CALC when the counter reaches 0.
- FIX:
  - quotient_next = sign_q ? -Q : Q.
  - remainder_next = sign_r ? -P[WIDTH-1:0] : P[WIDTH-1:0].
  - All results taken mod 2^WIDTH.
- DONE:
  - quotient, remainder, div_by_zero and overflow registered.
  - done=1 for exactly this cycle. busy=0 in the same cycle.
- Latency: fixed for every case, including divide-by-zero. done is high during the cycle following the (WIDTH+2)th rising edge after the edge that accepted start.
- busy=1 through CALC and FIX.
- Outputs hold their values after done until the next DONE state or reset.
- start while busy or in DONE is ignored. No queuing, and operand changes have no effect.
- start in the same cycle done is high is ignored. The earliest acceptance is the next IDLE cycle.
- Divide-by-zero (divisor==0):
  - Iterations run normally; the result is overridden at FIX.
  - quotient = all ones (-1), remainder = dividend, div_by_zero=1, overflow=0.
- Overflow (dividend = -2^(WIDTH-1), divisor = -1):
  - quotient = -2^(WIDTH-1) (wrapped), remainder=0, overflow=1.
- div_by_zero and overflow are cleared to 0 on any non-exceptional result.
- Invariant for non-exception cases: dividend == quotient*divisor + remainder, with |remainder| < |divisor|.

Test Plan:
- WIDTH=4, 7/2: done exactly 6 edges after the start edge. quotient=4'b0011, remainder=4'b0001, flags 0.
- -7/2 and 7/-2: quotient=4'b1101 (-3) in both. remainder=4'b1111 (-1) for -7/2, 4'b0001 (+1) for 7/-2.
- -8/-1 -> quotient=4'b1000, remainder=0, overflow=1. Then -8/1 -> quotient=4'b1000, remainder=0, overflow=0.
- 5/0 -> quotient=4'b1111, remainder=4'b0101, div_by_zero=1, same latency as a normal division.
- Start 6/3, then pulse start with 7/2 two cycles later: second start ignored, result quotient=2, remainder=0, single done pulse. Assert rst mid-CALC: busy=0 and outputs 0 immediately, no done.
- Exhaustive WIDTH=4 sweep of all 256 operand pairs with back-to-back starts: the invariant holds and each case matches a reference model.
